// File: rtl/prakh_pkg.sv
// rtl/prakh_pkg.sv - opcode encodings and flag bit positions for the prakh accumulator tile
package prakh_pkg;

  typedef logic [7:0] byte_t;

  localparam logic [2:0] OP_LOAD = 3'd0;
  localparam logic [2:0] OP_ADD  = 3'd1;
  localparam logic [2:0] OP_SUB  = 3'd2;
  localparam logic [2:0] OP_AND  = 3'd3;
  localparam logic [2:0] OP_OR   = 3'd4;
  localparam logic [2:0] OP_XOR  = 3'd5;
  localparam logic [2:0] OP_SHL  = 3'd6;
  localparam logic [2:0] OP_INC  = 3'd7;

  // Flag positions inside uio_out: {V,N,C,Z} on the upper nibble
  localparam int unsigned FLAG_Z = 4;
  localparam int unsigned FLAG_C = 5;
  localparam int unsigned FLAG_N = 6;
  localparam int unsigned FLAG_V = 7;

  localparam byte_t UIO_OE_MASK = 8'hF0;

endpackage

// File: rtl/prakh_alu.sv
// rtl/prakh_alu.sv - combinational 8-bit ALU producing result, carry/borrow and overflow
module prakh_alu
  import prakh_pkg::*;
(
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic [2:0] op,
  output logic [7:0] r,
  output logic       c,
  output logic       v
);

  logic [8:0] sum9;
  logic [8:0] shl9;

  always_comb begin
    r    = 8'h00;
    c    = 1'b0;
    v    = 1'b0;
    sum9 = 9'h000;
    shl9 = 9'h000;
    case (op)
      OP_LOAD: r = b;
      OP_ADD: begin
        sum9 = {1'b0, a} + {1'b0, b};
        r    = sum9[7:0];
        c    = sum9[8];
        v    = (a[7] == b[7]) && (r[7] != a[7]);
      end
      OP_SUB: begin
        r = a - b;
        c = (a < b);
        v = (a[7] != b[7]) && (r[7] != a[7]);
      end
      OP_AND: r = a & b;
      OP_OR:  r = a | b;
      OP_XOR: r = a ^ b;
      OP_SHL: begin
        // Bit 8 of the widened shift is the last bit pushed out; zero when s==0
        shl9 = {1'b0, a} << b[2:0];
        r    = shl9[7:0];
        c    = shl9[8];
      end
      OP_INC: begin
        r = a + 8'd1;
        c = (a == 8'hFF);
        v = (a == 8'h7F);
      end
      default: r = 8'h00;
    endcase
  end

endmodule

// File: rtl/prakh_test.sv
// rtl/prakh_test.sv - Tiny Tapeout tile: accumulator ALU with registered carry/overflow
module prakh_test
  import prakh_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  logic [7:0] acc_q, acc_d;
  logic       c_q, c_d;
  logic       v_q, v_d;
  logic [7:0] alu_r;
  logic       alu_c;
  logic       alu_v;
  logic       exec;
  logic       unused_uio_hi;

  assign exec          = ena & uio_in[3];
  assign unused_uio_hi = &{1'b0, uio_in[7:4]};

  prakh_alu u_alu (
    .a  (acc_q),
    .b  (ui_in),
    .op (uio_in[2:0]),
    .r  (alu_r),
    .c  (alu_c),
    .v  (alu_v)
  );

  always_comb begin
    acc_d = acc_q;
    c_d   = c_q;
    v_d   = v_q;
    if (exec) begin
      acc_d = alu_r;
      c_d   = alu_c;
      v_d   = alu_v;
    end
  end

  // rst_n is active-high on this tile despite its name
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      acc_q <= 8'h00;
      c_q   <= 1'b0;
      v_q   <= 1'b0;
    end else begin
      acc_q <= acc_d;
      c_q   <= c_d;
      v_q   <= v_d;
    end
  end

  always_comb begin
    uio_out         = 8'h00;
    uio_out[FLAG_Z] = (acc_q == 8'h00);
    uio_out[FLAG_C] = c_q;
    uio_out[FLAG_N] = acc_q[7];
    uio_out[FLAG_V] = v_q;
  end

  assign uo_out = acc_q;
  assign uio_oe = UIO_OE_MASK;

endmodule

// File: tb/tb_prakh_test.sv
// tb/tb_prakh_test.sv - directed vector bench for the prakh accumulator tile
module tb_prakh_test;
  import prakh_pkg::*;

  logic       clk;
  logic       rst_n;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uo_out;
  logic [7:0] uio_in;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  int checks;
  int errors;

  typedef struct {
    logic [2:0] op;
    logic [7:0] b;
    logic       exec;
    logic       en;
    logic [3:0] hi;
    logic [7:0] exp_acc;
    logic [7:0] exp_uio;
  } vec_t;

  vec_t vecs[$];

  prakh_test dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ena     (ena),
    .ui_in   (ui_in),
    .uo_out  (uo_out),
    .uio_in  (uio_in),
    .uio_out (uio_out),
    .uio_oe  (uio_oe)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, got, exp);
    end
  endtask

  task automatic drive(input logic [2:0] op, input logic [7:0] b, input logic exec,
                       input logic en, input logic [3:0] hi);
    ui_in  = b;
    uio_in = {hi, exec, op};
    ena    = en;
  endtask

  task automatic step_check(input string name, input logic [7:0] exp_acc, input logic [7:0] exp_uio);
    @(posedge clk);
    #1;
    check({name, "_acc"}, uo_out, exp_acc);
    check({name, "_uio"}, uio_out, exp_uio);
    @(negedge clk);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b1;
    drive(OP_LOAD, 8'h00, 1'b0, 1'b0, 4'h0);

    vecs.push_back('{OP_LOAD, 8'h5A, 1'b1, 1'b1, 4'h0, 8'h5A, 8'h00});
    vecs.push_back('{OP_LOAD, 8'hF0, 1'b1, 1'b1, 4'h0, 8'hF0, 8'h40});
    vecs.push_back('{OP_ADD,  8'h20, 1'b1, 1'b1, 4'h0, 8'h10, 8'h20});
    vecs.push_back('{OP_LOAD, 8'h7F, 1'b1, 1'b1, 4'h0, 8'h7F, 8'h00});
    vecs.push_back('{OP_ADD,  8'h01, 1'b1, 1'b1, 4'h0, 8'h80, 8'hC0});
    vecs.push_back('{OP_LOAD, 8'h05, 1'b1, 1'b1, 4'h0, 8'h05, 8'h00});
    vecs.push_back('{OP_SUB,  8'h06, 1'b1, 1'b1, 4'h0, 8'hFF, 8'h60});
    vecs.push_back('{OP_LOAD, 8'h80, 1'b1, 1'b1, 4'h0, 8'h80, 8'h40});
    vecs.push_back('{OP_SUB,  8'h01, 1'b1, 1'b1, 4'h0, 8'h7F, 8'h80});
    vecs.push_back('{OP_LOAD, 8'h33, 1'b1, 1'b1, 4'h0, 8'h33, 8'h00});
    vecs.push_back('{OP_SUB,  8'h33, 1'b1, 1'b1, 4'h0, 8'h00, 8'h10});
    vecs.push_back('{OP_LOAD, 8'hF0, 1'b1, 1'b1, 4'h0, 8'hF0, 8'h40});
    vecs.push_back('{OP_AND,  8'h3C, 1'b1, 1'b1, 4'h0, 8'h30, 8'h00});
    vecs.push_back('{OP_OR,   8'h0F, 1'b1, 1'b1, 4'h0, 8'h3F, 8'h00});
    vecs.push_back('{OP_XOR,  8'hFF, 1'b1, 1'b1, 4'h0, 8'hC0, 8'h40});
    vecs.push_back('{OP_LOAD, 8'h81, 1'b1, 1'b1, 4'h0, 8'h81, 8'h40});
    vecs.push_back('{OP_SHL,  8'h01, 1'b1, 1'b1, 4'h0, 8'h02, 8'h20});
    vecs.push_back('{OP_SHL,  8'hF8, 1'b1, 1'b1, 4'h0, 8'h02, 8'h00});
    vecs.push_back('{OP_LOAD, 8'h03, 1'b1, 1'b1, 4'h0, 8'h03, 8'h00});
    vecs.push_back('{OP_SHL,  8'h07, 1'b1, 1'b1, 4'h0, 8'h80, 8'h60});
    vecs.push_back('{OP_LOAD, 8'hFF, 1'b1, 1'b1, 4'h0, 8'hFF, 8'h40});
    vecs.push_back('{OP_INC,  8'h42, 1'b1, 1'b1, 4'h0, 8'h00, 8'h30});
    vecs.push_back('{OP_LOAD, 8'h55, 1'b0, 1'b1, 4'h0, 8'h00, 8'h30});
    vecs.push_back('{OP_LOAD, 8'h55, 1'b1, 1'b0, 4'h0, 8'h00, 8'h30});
    vecs.push_back('{OP_LOAD, 8'h12, 1'b1, 1'b1, 4'hF, 8'h12, 8'h00});
    vecs.push_back('{OP_ADD,  8'h7F, 1'b1, 1'b1, 4'hA, 8'h91, 8'hC0});
    vecs.push_back('{OP_LOAD, 8'h7F, 1'b1, 1'b1, 4'h0, 8'h7F, 8'h00});
    vecs.push_back('{OP_INC,  8'h00, 1'b1, 1'b1, 4'h0, 8'h80, 8'hC0});

    repeat (2) @(posedge clk);
    #1;
    check("reset_acc", uo_out, 8'h00);
    check("reset_uio", uio_out, 8'h10);
    check("reset_oe",  uio_oe,  8'hF0);
    @(negedge clk);
    rst_n = 1'b0;

    foreach (vecs[i]) begin
      drive(vecs[i].op, vecs[i].b, vecs[i].exec, vecs[i].en, vecs[i].hi);
      step_check($sformatf("vec%0d", i), vecs[i].exp_acc, vecs[i].exp_uio);
    end

    // Hold for 5 cycles alternating EXEC low and ena low; ACC=80, V=1, N=1
    for (int k = 0; k < 5; k++) begin
      if (k % 2 == 0) drive(OP_XOR, 8'hFF, 1'b0, 1'b1, 4'h0);
      else            drive(OP_XOR, 8'hFF, 1'b1, 1'b0, 4'h0);
      step_check($sformatf("hold%0d", k), 8'h80, 8'hC0);
    end

    // EXEC held while ena low, then ena rises and executes on the next edge
    drive(OP_LOAD, 8'h77, 1'b1, 1'b0, 4'h0);
    step_check("ena_low", 8'h80, 8'hC0);
    drive(OP_LOAD, 8'h77, 1'b1, 1'b1, 4'h0);
    step_check("ena_rise", 8'h77, 8'h00);

    drive(OP_LOAD, 8'h00, 1'b1, 1'b1, 4'h0);
    step_check("load0", 8'h00, 8'h10);
    drive(OP_INC, 8'h00, 1'b1, 1'b1, 4'h0);
    step_check("inc1", 8'h01, 8'h00);
    step_check("inc2", 8'h02, 8'h00);
    step_check("inc3", 8'h03, 8'h00);

    // Asynchronous reset between edges with EXEC still high
    #2;
    rst_n = 1'b1;
    #1;
    check("async_acc", uo_out, 8'h00);
    check("async_uio", uio_out, 8'h10);
    @(posedge clk);
    #1;
    check("async_hold_acc", uo_out, 8'h00);
    @(negedge clk);
    rst_n = 1'b0;
    step_check("post_reset_inc", 8'h01, 8'h00);
    check("final_oe", uio_oe, 8'hF0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
